// File: rtl/lr35902_ppu_pxfifo.sv
// Pixel FIFO and mixer for the LR35902 PPU: queues BG fetcher rows, overlays
// object rows onto the oldest queued pixels, applies fine-scroll discard and
// maps each shifted pixel through the BG or object palette.
module lr35902_ppu_pxfifo #(
    parameter int DEPTH    = 16,
    parameter int MIN_FILL = 8,
    parameter int WIDTH    = 160
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         line_start,
    input  logic [2:0]                   scx_fine,
    input  logic                         bg_push,
    input  logic [7:0]                   bg_lo,
    input  logic [7:0]                   bg_hi,
    output logic                         bg_ready,
    input  logic                         obj_merge,
    input  logic [7:0]                   obj_lo,
    input  logic [7:0]                   obj_hi,
    input  logic                         obj_pal,
    input  logic                         obj_prio,
    output logic                         obj_ready,
    input  logic                         stall,
    input  logic                         bg_ena,
    input  logic                         obj_ena,
    input  logic [7:0]                   bgp,
    input  logic [7:0]                   obp0,
    input  logic [7:0]                   obp1,
    output logic                         px_out,
    output logic [1:0]                   px,
    output logic [7:0]                   px_cnt,
    output logic                         line_done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_len
);
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0] bg;
        logic [1:0] oc;
        logic       pal;
        logic       prio;
    } slot_t;

    // slot_cur[0] is the oldest queued pixel
    slot_t         slot_cur [DEPTH];
    logic [LW-1:0] len_reg;
    logic [7:0]    cnt_reg;
    logic [2:0]    disc_reg;
    logic          px_out_reg;
    logic [1:0]    px_reg;

    logic          do_shift;
    logic          do_merge;
    logic          do_push;
    logic          flush;
    logic [LW-1:0] push_base;
    logic [1:0]    push_px [8];
    slot_t         head;
    logic [1:0]    bg_eff;
    logic [1:0]    mix_next;

    assign line_done = (cnt_reg == 8'(WIDTH));
    assign bg_ready  = (len_reg <= LW'(DEPTH - 8)) && !line_done;
    assign obj_ready = (len_reg >= LW'(8)) && !line_done;

    // Event priority: line_start overrides everything; merge holds off the shift.
    assign do_shift  = !line_start && !line_done && !stall && !obj_merge &&
                       (len_reg > LW'(MIN_FILL));
    assign do_merge  = !line_start && obj_merge && obj_ready;
    assign do_push   = !line_start && bg_push && bg_ready;
    assign flush     = line_start || line_done;

    // New row lands right behind whatever survives this cycle's shift.
    assign push_base = len_reg - LW'(do_shift);
    assign head      = slot_cur[0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_push_px
            assign push_px[gi] = {bg_hi[7-gi], bg_lo[7-gi]};
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            slot_t      q_reg;
            slot_t      d_next;
            slot_t      up;
            logic [1:0] obj_c;

            if (gi < DEPTH - 1) begin : g_up
                assign up = slot_cur[gi+1];
            end else begin : g_up_end
                assign up = '0;
            end

            // Only the 8 oldest slots are reachable by an object row.
            if (gi < 8) begin : g_obj
                assign obj_c = {obj_hi[7-gi], obj_lo[7-gi]};
            end else begin : g_no_obj
                assign obj_c = 2'd0;
            end

            // Next slot contents: shift, then object overlay (first object wins), then push.
            always_comb begin
                int off;
                d_next = q_reg;
                off    = gi - int'(push_base);
                if (do_shift) begin
                    d_next = up;
                end
                if (do_merge && obj_c != 2'd0 && d_next.oc == 2'd0) begin
                    d_next.oc   = obj_c;
                    d_next.pal  = obj_pal;
                    d_next.prio = obj_prio;
                end
                if (do_push && off >= 0 && off < 8) begin
                    d_next.bg   = push_px[off[2:0]];
                    d_next.oc   = 2'd0;
                    d_next.pal  = 1'b0;
                    d_next.prio = 1'b0;
                end
                if (flush) begin
                    d_next = '0;
                end
            end

            // Slot storage register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= d_next;
                end
            end

            assign slot_cur[gi] = q_reg;
        end
    endgenerate

    // Mix the head slot: object wins unless transparent or behind a non-zero BG.
    always_comb begin
        bg_eff   = bg_ena ? head.bg : 2'd0;
        mix_next = bgp[{bg_eff, 1'b0} +: 2];
        if (obj_ena && head.oc != 2'd0 && !(head.prio && bg_eff != 2'd0)) begin
            mix_next = head.pal ? obp1[{head.oc, 1'b0} +: 2] : obp0[{head.oc, 1'b0} +: 2];
        end
    end

    // Occupancy, pixel counter, discard counter and registered pixel output.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg    <= '0;
            cnt_reg    <= 8'd0;
            disc_reg   <= 3'd0;
            px_out_reg <= 1'b0;
            px_reg     <= 2'd0;
        end else if (line_start) begin
            len_reg    <= '0;
            cnt_reg    <= 8'd0;
            disc_reg   <= scx_fine;
            px_out_reg <= 1'b0;
        end else if (line_done) begin
            len_reg    <= '0;
            px_out_reg <= 1'b0;
        end else begin
            len_reg    <= len_reg - LW'(do_shift) + (do_push ? LW'(8) : LW'(0));
            px_out_reg <= 1'b0;
            if (do_shift) begin
                if (disc_reg != 3'd0) begin
                    disc_reg <= disc_reg - 3'd1;
                end else begin
                    cnt_reg    <= cnt_reg + 8'd1;
                    px_out_reg <= 1'b1;
                    px_reg     <= mix_next;
                end
            end
        end
    end

    assign px_out   = px_out_reg;
    assign px       = px_reg;
    assign px_cnt   = cnt_reg;
    assign fifo_len = len_reg;

endmodule

// File: tb/tb_lr35902_ppu_pxfifo.sv
// Bench for lr35902_ppu_pxfifo: directed vector table, full-line sequences and
// randomized traffic compared against a queue-based reference model on three
// parameterisations sharing the same inputs.
module tb_lr35902_ppu_pxfifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       line_start;
    logic [2:0] scx_fine;
    logic       bg_push;
    logic [7:0] bg_lo, bg_hi;
    logic       obj_merge;
    logic [7:0] obj_lo, obj_hi;
    logic       obj_pal, obj_prio;
    logic       stall;
    logic       bg_ena, obj_ena;
    logic [7:0] bgp, obp0, obp1;

    logic       pxo_o [3];
    logic [1:0] px_o  [3];
    logic [7:0] cnt_o [3];
    logic       ld_o  [3];
    logic       bgr_o [3];
    logic       objr_o[3];
    logic [4:0] len_o [3];

    always #5 clk = ~clk;

    lr35902_ppu_pxfifo #(.DEPTH(16), .MIN_FILL(8), .WIDTH(160)) u_a (
        .clk(clk), .reset(reset), .line_start(line_start), .scx_fine(scx_fine),
        .bg_push(bg_push), .bg_lo(bg_lo), .bg_hi(bg_hi), .bg_ready(bgr_o[0]),
        .obj_merge(obj_merge), .obj_lo(obj_lo), .obj_hi(obj_hi), .obj_pal(obj_pal),
        .obj_prio(obj_prio), .obj_ready(objr_o[0]), .stall(stall), .bg_ena(bg_ena),
        .obj_ena(obj_ena), .bgp(bgp), .obp0(obp0), .obp1(obp1), .px_out(pxo_o[0]),
        .px(px_o[0]), .px_cnt(cnt_o[0]), .line_done(ld_o[0]), .fifo_len(len_o[0]));

    lr35902_ppu_pxfifo #(.DEPTH(24), .MIN_FILL(16), .WIDTH(160)) u_b (
        .clk(clk), .reset(reset), .line_start(line_start), .scx_fine(scx_fine),
        .bg_push(bg_push), .bg_lo(bg_lo), .bg_hi(bg_hi), .bg_ready(bgr_o[1]),
        .obj_merge(obj_merge), .obj_lo(obj_lo), .obj_hi(obj_hi), .obj_pal(obj_pal),
        .obj_prio(obj_prio), .obj_ready(objr_o[1]), .stall(stall), .bg_ena(bg_ena),
        .obj_ena(obj_ena), .bgp(bgp), .obp0(obp0), .obp1(obp1), .px_out(pxo_o[1]),
        .px(px_o[1]), .px_cnt(cnt_o[1]), .line_done(ld_o[1]), .fifo_len(len_o[1]));

    lr35902_ppu_pxfifo #(.DEPTH(24), .MIN_FILL(8), .WIDTH(20)) u_c (
        .clk(clk), .reset(reset), .line_start(line_start), .scx_fine(scx_fine),
        .bg_push(bg_push), .bg_lo(bg_lo), .bg_hi(bg_hi), .bg_ready(bgr_o[2]),
        .obj_merge(obj_merge), .obj_lo(obj_lo), .obj_hi(obj_hi), .obj_pal(obj_pal),
        .obj_prio(obj_prio), .obj_ready(objr_o[2]), .stall(stall), .bg_ena(bg_ena),
        .obj_ena(obj_ena), .bgp(bgp), .obp0(obp0), .obp1(obp1), .px_out(pxo_o[2]),
        .px(px_o[2]), .px_cnt(cnt_o[2]), .line_done(ld_o[2]), .fifo_len(len_o[2]));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] bg;
        logic [1:0] oc;
        logic       pal;
        logic       prio;
    } mslot_t;

    mslot_t     mq [3][$];
    int         m_cnt [3];
    int         m_disc[3];
    bit         m_pxo [3];
    logic [1:0] m_px  [3];
    int         dp[3] = '{16, 24, 24};
    int         mf[3] = '{8, 16, 8};
    int         wd[3] = '{160, 160, 20};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [1:0] mix_px(mslot_t s);
        int b;
        int c;
        b = bg_ena ? int'(s.bg) : 0;
        c = int'(s.oc);
        if (obj_ena && c != 0 && !(s.prio && b != 0))
            return 2'((s.pal ? obp1 : obp0) >> (2 * c));
        return 2'(bgp >> (2 * b));
    endfunction

    task automatic model_step(input int k);
        int     len;
        bit     sh;
        mslot_t s;
        logic [1:0] c;
        if (reset) begin
            mq[k].delete(); m_cnt[k] = 0; m_disc[k] = 0; m_pxo[k] = 0; m_px[k] = 2'd0;
            return;
        end
        if (line_start) begin
            mq[k].delete(); m_cnt[k] = 0; m_disc[k] = int'(scx_fine); m_pxo[k] = 0;
            return;
        end
        if (m_cnt[k] == wd[k]) begin
            mq[k].delete(); m_pxo[k] = 0;
            return;
        end
        len = mq[k].size();
        sh  = (len > mf[k]) && !stall && !obj_merge;
        m_pxo[k] = 0;
        if (sh) begin
            s = mq[k].pop_front();
            if (m_disc[k] > 0) m_disc[k]--;
            else begin
                m_cnt[k]++;
                m_pxo[k] = 1;
                m_px[k]  = mix_px(s);
            end
        end
        if (obj_merge && len >= 8) begin
            for (int i = 0; i < 8; i++) begin
                c = {obj_hi[3'(7 - i)], obj_lo[3'(7 - i)]};
                s = mq[k][i];
                if (s.oc == 2'd0 && c != 2'd0) begin
                    s.oc = c; s.pal = obj_pal; s.prio = obj_prio;
                    mq[k][i] = s;
                end
            end
        end
        if (bg_push && len <= dp[k] - 8) begin
            for (int j = 0; j < 8; j++) begin
                s = '0;
                s.bg = {bg_hi[3'(7 - j)], bg_lo[3'(7 - j)]};
                mq[k].push_back(s);
            end
        end
    endtask

    task automatic check(input string nm, input int inst, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cycle=%0d got=%0d expected=%0d", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        bit ld;
        for (int k = 0; k < 3; k++) begin
            ld = (m_cnt[k] == wd[k]);
            check("mdl_len",  k, int'(len_o[k]), mq[k].size());
            check("mdl_cnt",  k, int'(cnt_o[k]), m_cnt[k]);
            check("mdl_pxo",  k, int'(pxo_o[k]), int'(m_pxo[k]));
            if (m_pxo[k]) check("mdl_px", k, int'(px_o[k]), int'(m_px[k]));
            check("mdl_done", k, int'(ld_o[k]), int'(ld));
            check("mdl_bgr",  k, int'(bgr_o[k]), int'(mq[k].size() <= dp[k] - 8 && !ld));
            check("mdl_objr", k, int'(objr_o[k]), int'(mq[k].size() >= 8 && !ld));
        end
    endtask

    // One clock: model consumes the inputs the DUTs see at the next edge.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        check_model();
    endtask

    task automatic idle_inputs();
        reset = 0; line_start = 0; scx_fine = 0; bg_push = 0; bg_lo = 0; bg_hi = 0;
        obj_merge = 0; obj_lo = 0; obj_hi = 0; obj_pal = 0; obj_prio = 0; stall = 0;
        bg_ena = 1; obj_ena = 1;
    endtask

    // ---------------- directed vector table (instance a) ----------------
    typedef struct {
        logic       ls;
        logic [2:0] scx;
        logic       push;
        logic [7:0] blo, bhi;
        logic       merge;
        logic [7:0] olo, ohi;
        logic       pal, prio, stl, bgena;
        logic       epxo;
        logic [1:0] epx;
        int         elen;
        int         ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ls, input logic [2:0] scx, input logic push,
                                input logic [7:0] blo, input logic [7:0] bhi,
                                input logic merge, input logic [7:0] olo, input logic [7:0] ohi,
                                input logic pal, input logic prio, input logic stl,
                                input logic bgena, input logic epxo, input logic [1:0] epx,
                                input int elen, input int ecnt);
        vec_t v;
        v.ls = ls; v.scx = scx; v.push = push; v.blo = blo; v.bhi = bhi;
        v.merge = merge; v.olo = olo; v.ohi = ohi; v.pal = pal; v.prio = prio;
        v.stl = stl; v.bgena = bgena; v.epxo = epxo; v.epx = epx;
        v.elen = elen; v.ecnt = ecnt;
        tbl.push_back(v);
    endfunction

    // n idle cycles that each shift one pixel out of a fifo starting at len0
    function automatic void add_shifts(input int n, input logic [1:0] pxv, input int len0,
                                       input int cnt0, input logic bgena, input logic vis);
        for (int i = 0; i < n; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, bgena, vis, pxv, len0 - 1 - i,
                vis ? cnt0 + 1 + i : cnt0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1;
        bit done;

        idle_inputs();
        bgp = 8'hE4; obp0 = 8'hE4; obp1 = 8'h1B;

        // reset state, with a push held high that must be ignored
        reset = 1; bg_push = 1; bg_lo = 8'hFF;
        for (int i = 0; i < 3; i++) tick();
        for (int k = 0; k < 3; k++) begin
            check("rst_pxo",  k, int'(pxo_o[k]), 0);
            check("rst_len",  k, int'(len_o[k]), 0);
            check("rst_cnt",  k, int'(cnt_o[k]), 0);
            check("rst_done", k, int'(ld_o[k]), 0);
            check("rst_bgr",  k, int'(bgr_o[k]), 1);
            check("rst_objr", k, int'(objr_o[k]), 0);
        end
        idle_inputs();

        // basic streaming, bgp identity so BG colour 1 -> shade 1
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 0);
        add(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16, 0);
        add_shifts(8, 1, 16, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 8);
        // object overlay: colour 3 via OBP1 (1B) -> shade 0; second row only fills slots 4-7
        add(0, 0, 0, 0, 0, 1, 8'hF0, 8'hF0, 1, 0, 0, 1, 0, 0, 8, 8);
        add(0, 0, 0, 0, 0, 1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 0, 8, 8);
        add(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16, 8);
        add_shifts(4, 0, 16, 8, 1, 1);
        add_shifts(4, 3, 12, 12, 1, 1);
        // priority: BG colour 2 over object colour 1 (prio=1), then BG disabled
        add(0, 0, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16, 16);
        add_shifts(8, 1, 16, 16, 1, 1);
        add(0, 0, 0, 0, 0, 1, 8'hFF, 0, 0, 1, 0, 1, 0, 0, 8, 24);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16, 24);
        add_shifts(4, 2, 16, 24, 1, 1);
        add_shifts(4, 1, 12, 28, 0, 1);
        // push dropped at fifo_len 9, both stalled and alongside a shift
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16, 32);
        add_shifts(7, 0, 16, 32, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 9, 39);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 8, 40);
        // fine scroll: 5 hidden pixels before the first visible one
        add(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 0);
        add(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16, 0);
        add_shifts(5, 0, 16, 0, 1, 0);
        add_shifts(3, 1, 11, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 3);

        foreach (tbl[r]) begin
            line_start = tbl[r].ls; scx_fine = tbl[r].scx; bg_push = tbl[r].push;
            bg_lo = tbl[r].blo; bg_hi = tbl[r].bhi; obj_merge = tbl[r].merge;
            obj_lo = tbl[r].olo; obj_hi = tbl[r].ohi; obj_pal = tbl[r].pal;
            obj_prio = tbl[r].prio; stall = tbl[r].stl; bg_ena = tbl[r].bgena;
            obj_ena = 1;
            tick();
            check("vec_pxo", r, int'(pxo_o[0]), int'(tbl[r].epxo));
            if (tbl[r].epxo) check("vec_px", r, int'(px_o[0]), int'(tbl[r].epx));
            check("vec_len", r, int'(len_o[0]), tbl[r].elen);
            check("vec_cnt", r, int'(cnt_o[0]), tbl[r].ecnt);
            check("vec_bgr", r, int'(bgr_o[0]), int'(tbl[r].elen <= 8));
            check("vec_objr", r, int'(objr_o[0]), int'(tbl[r].elen >= 8));
            $display("[TB] row %0d px_out=%0d px=%0d fifo_len=%0d px_cnt=%0d",
                     r, pxo_o[0], px_o[0], len_o[0], cnt_o[0]);
        end

        // full 160-pixel line with continuous pushes on both 160-wide instances
        idle_inputs();
        line_start = 1;
        tick();
        line_start = 0; bg_push = 1; bg_lo = 8'hFF; bg_hi = 8'h00;
        p0 = 0; p1 = 0; done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            tick();
            if (pxo_o[0]) p0++;
            if (pxo_o[1]) p1++;
            done = ld_o[0] && ld_o[1];
        end
        $display("[TB] full line: pulses a=%0d b=%0d done=%0d", p0, p1, done);
        check("line_finished", 0, int'(done), 1);
        check("line_pulses", 0, p0, 160);
        check("line_pulses", 1, p1, 160);
        tick();
        for (int k = 0; k < 2; k++) begin
            check("line_len_zero", k, int'(len_o[k]), 0);
            check("line_bgr_low",  k, int'(bgr_o[k]), 0);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            check("line_push_ignored", k, int'(len_o[k]), 0);
            check("line_cnt_sat",      k, int'(cnt_o[k]), 160);
        end
        bg_push = 0; line_start = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("restart_done", k, int'(ld_o[k]), 0);
            check("restart_bgr",  k, int'(bgr_o[k]), 1);
        end

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            line_start = ($urandom_range(0, 149) == 0);
            scx_fine   = 3'($urandom_range(0, 7));
            bg_push    = 1'($urandom_range(0, 1));
            bg_lo      = 8'($urandom); bg_hi = 8'($urandom);
            obj_merge  = ($urandom_range(0, 4) == 0);
            obj_lo     = 8'($urandom); obj_hi = 8'($urandom);
            obj_pal    = 1'($urandom_range(0, 1));
            obj_prio   = 1'($urandom_range(0, 1));
            stall      = ($urandom_range(0, 4) == 0);
            bg_ena     = ($urandom_range(0, 7) != 0);
            obj_ena    = ($urandom_range(0, 7) != 0);
            bgp        = 8'($urandom); obp0 = 8'($urandom); obp1 = 8'($urandom);
            tick();
            if (line_start || reset)
                $display("[TB] random cycle %0d reset=%0d line_start=%0d", i, reset, line_start);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
